prog_pattern_detector: RTL and testbench
========================================

Name: prog_pattern_detector

Overview:
Serial bit-stream pattern detector with a run-time programmable pattern and length (1..PAT_W), selectable overlapping or non-overlapping detection, and a saturating match counter. It is the parametrised successor to the fixed-pattern detector and sits directly on the serial input path. It flags each match with a one-cycle pulse and keeps a running match count for status readout.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 16, match counter width
DEFAULT_PAT, 8'h0B, pattern loaded at reset (right-aligned, PAT_W bits)
DEFAULT_LEN, 4, pattern length loaded at reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
stream_in  in  1  serial data bit
stream_valid  in  1  stream_in is sampled only when 1
cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap; clear history
cfg_pattern  in  PAT_W  pattern, right-aligned; bit [len-1] is the first bit in time, bit [0] the last
cfg_len  in  $clog2(PAT_W+1)  active pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
clear_count  in  1  synchronous clear of match_count/count_sat
pattern_found  out  1  one-cycle match pulse (registered)
match_count  out  CNT_W  number of matches, saturating
count_sat  out  1  sticky; match_count has saturated
cfg_err  out  1  active config invalid (len 0 or >PAT_W); detection disabled

Behaviour:
- Reset (async, any time): pattern=DEFAULT_PAT, len=DEFAULT_LEN, overlap=1, history=0, fill=0, pattern_found=0, match_count=0, count_sat=0, cfg_err=0. Reset mid-stream discards partial matches.
- State: history shift register (PAT_W-1 bits), fill counter 0..PAT_W (valid bits since last clear, saturating), active config registers.
- Valid bit accepted on a rising edge with stream_valid=1 and cfg_load=0: history <= {history, stream_in}; fill <= min(fill+1, PAT_W).
- Match is evaluated on the accepted bit. Window = low len bits of {history, stream_in}. Match when !cfg_err, fill+1 >= len, and window == cfg_pattern[len-1:0].
- Latency: pattern_found is set on the same edge that accepts the final bit. It is high for exactly that following cycle and is cleared on the next edge unless another match occurs.
- Overlap=1: fill is unaffected by a match, so back-to-back matches are possible (len=1 pattern '1' pulses every valid '1').
- Overlap=0: on a match, fill <= 0. The next match needs len fresh bits.
- stream_valid=0: no shift and no match; pattern_found <= 0. Gaps do not break a partial match.
- cfg_load: has priority over stream_valid. The bit presented in the same cycle is discarded. Active config is latched; history=0, fill=0, pattern_found<=0. cfg_err <= (cfg_len==0 || cfg_len>PAT_W). match_count is untouched.
- Counter: on a match, match_count increments. At all-ones it holds and count_sat <= 1. clear_count takes priority: count <= (match ? 1 : 0), count_sat <= 0.

Decomposition:
- Package prog_pd_pkg: LEN_W = $clog2(PAT_W+1) helper function, and a len-to-mask function producing the PAT_W-bit compare mask.
- One sub-module, pd_match_counter: saturating counter with inc, clr, count and sat, parametrised by CNT_W.

Test Plan:
- Reset default (1011, len 4, overlap), stream 1,0,1,1,0,1,1 -> pattern_found pulses after the 4th and 7th bits; match_count=2.
- Load pattern 1011, len 4, overlap=0, same stream -> single pulse after the 4th bit; match_count=1.
- Load len 8, pattern 8'hA5. Stream 1010 0101 with stream_valid dropped for 3 cycles mid-stream -> one pulse after the 8th valid bit. Then assert cfg_load after 5 bits of a second A5 -> no pulse for that sequence.
- Load cfg_len=0 -> cfg_err=1 and no pulses on any stream. Load len 3 -> cfg_err=0.
- CNT_W=3, len 1, pattern '1', overlap, 9 valid ones -> count stops at 7 with count_sat=1. clear_count on the same cycle as a match -> count=1, count_sat=0.
- Assert rst mid-pattern after 3 of 4 bits, release, then send the 4th bit -> no pulse; all outputs are 0 during reset.

Source files
------------

// File: rtl/prog_pd_pkg.sv
// Shared helpers for the programmable pattern detector: length-field sizing
// and the right-aligned compare mask derived from the active pattern length.
package prog_pd_pkg;

  localparam int MAX_PAT_W = 64;

  function automatic int calc_len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Bit i is set for every i below len; callers narrow the result to PAT_W.
  function automatic logic [MAX_PAT_W-1:0] len_to_mask(input int len);
    logic [MAX_PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PAT_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pd_match_counter.sv
// Saturating match counter; clear wins over increment but still counts a
// match that lands on the clearing edge.
module pd_match_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_count;
  logic             r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_count <= i_inc ? CNT_W'(1) : '0;
      r_sat   <= 1'b0;
    end else if (i_inc) begin
      // A match arriving at all-ones is lost, so that is when sat latches.
      if (&r_count) r_sat <= 1'b1;
      else          r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/prog_pattern_detector.sv
// Serial pattern detector with run-time pattern/length, optional overlap and
// a saturating match counter. The pulse is registered on the accepting edge.
module prog_pattern_detector
  import prog_pd_pkg::*;
#(
  parameter int             PAT_W       = 8,
  parameter int             CNT_W       = 16,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(8'h0B),
  parameter int             DEFAULT_LEN = 4,
  localparam int            LEN_W       = calc_len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stream_in,
  input  logic             stream_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clear_count,
  output logic             pattern_found,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic             cfg_err
);

  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W-1:0] r_len;
  logic [PAT_W-1:0] r_pat;
  logic             r_overlap;
  logic             r_cfg_err;
  logic             r_found;

  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_mask;
  logic             w_accept;
  logic             w_enough;
  logic             w_match;
  logic             w_cfg_bad;

  assign w_window  = {r_hist, stream_in};
  assign w_mask    = PAT_W'(len_to_mask(int'(r_len)));
  assign w_accept  = stream_valid & ~cfg_load;
  assign w_enough  = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};
  assign w_match   = w_accept & ~r_cfg_err & w_enough &
                     (((w_window ^ r_pat) & w_mask) == '0);
  assign w_cfg_bad = (cfg_len == '0) || (cfg_len > LEN_W'(PAT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_pat     <= DEFAULT_PAT;
      r_overlap <= 1'b1;
      r_cfg_err <= 1'b0;
      r_found   <= 1'b0;
    end else begin
      r_found <= w_match;
      if (cfg_load) begin
        r_pat     <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_cfg_err <= w_cfg_bad;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (stream_valid) begin
        r_hist <= w_window[PAT_W-2:0];
        // Non-overlap restarts the fill so the next match needs len fresh bits.
        if (w_match && !r_overlap)          r_fill <= '0;
        else if (r_fill != LEN_W'(PAT_W))   r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

  pd_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_match),
    .i_clr   (clear_count),
    .o_count (match_count),
    .o_sat   (count_sat)
  );

  assign pattern_found = r_found;
  assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_prog_pattern_detector.sv
// Directed bench for prog_pattern_detector; a second instance with a 3-bit
// counter shares the stimulus and exercises saturation.
module tb_prog_pattern_detector;

  logic        clk;
  logic        rst;
  logic        stream_in;
  logic        stream_valid;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        clear_count;
  logic        pattern_found;
  logic [15:0] match_count;
  logic        count_sat;
  logic        cfg_err;
  logic        pf2;
  logic [2:0]  mc2;
  logic        sat2;
  logic        err2;

  int total;
  int bad;

  prog_pattern_detector #(.PAT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stream_in(stream_in), .stream_valid(stream_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clear_count(clear_count),
    .pattern_found(pattern_found), .match_count(match_count),
    .count_sat(count_sat), .cfg_err(cfg_err)
  );

  prog_pattern_detector #(.PAT_W(8), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .stream_in(stream_in), .stream_valid(stream_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clear_count(clear_count),
    .pattern_found(pf2), .match_count(mc2),
    .count_sat(sat2), .cfg_err(err2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs sampled 1 after rising
  task automatic step(input logic v, input logic b, input logic ld, input logic clr);
    @(negedge clk);
    stream_valid = v;
    stream_in    = b;
    cfg_load     = ld;
    clear_count  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    @(negedge clk);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    stream_in = 1'b0; stream_valid = 1'b0; cfg_load = 1'b0; clear_count = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({pattern_found, match_count, count_sat, cfg_err} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got pf=%b cnt=%0d sat=%b err=%b, want all 0",
               pattern_found, match_count, count_sat, cfg_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_overlap;
    logic [6:0] bits;
    logic [6:0] exp_pf;
    bits   = 7'b1011011;
    exp_pf = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 1'b0);
      total++;
      if (pattern_found !== exp_pf[i]) begin
        bad++;
        $display("FAIL default_pf bit%0d: got %b want %b", 6 - i, pattern_found, exp_pf[i]);
      end
    end
    total++;
    if (match_count !== 16'd2) begin
      bad++;
      $display("FAIL default_count: got %0d want 2", match_count);
    end
  endtask

  task automatic test_non_overlap;
    logic [6:0] bits;
    logic [6:0] exp_pf;
    bits   = 7'b1011011;
    exp_pf = 7'b0001000;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_cfg(8'h0B, 4'd4, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 1'b0);
      total++;
      if (pattern_found !== exp_pf[i]) begin
        bad++;
        $display("FAIL nonovl_pf bit%0d: got %b want %b", 6 - i, pattern_found, exp_pf[i]);
      end
    end
    total++;
    if (match_count !== 16'd1) begin
      bad++;
      $display("FAIL nonovl_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_gaps_and_reload;
    logic [7:0] pat;
    pat = 8'hA5;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_cfg(8'hA5, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1, 1'b0, 1'b0);
          total++;
          if (pattern_found !== 1'b0) begin
            bad++;
            $display("FAIL gap_pf gap%0d: got %b want 0", g, pattern_found);
          end
        end
      end
      step(1'b1, pat[i], 1'b0, 1'b0);
      total++;
      if (pattern_found !== (i == 0)) begin
        bad++;
        $display("FAIL a5_pf bit%0d: got %b want %b", 7 - i, pattern_found, (i == 0));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (pattern_found !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width: got %b want 0", pattern_found);
    end
    for (int i = 7; i >= 3; i--) step(1'b1, pat[i], 1'b0, 1'b0);
    step(1'b1, pat[2], 1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      step(1'b1, pat[i], 1'b0, 1'b0);
      total++;
      if (pattern_found !== 1'b0) begin
        bad++;
        $display("FAIL reload_pf bit%0d: got %b want 0", 2 - i, pattern_found);
      end
    end
    total++;
    if (match_count !== 16'd1) begin
      bad++;
      $display("FAIL a5_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_cfg_err;
    logic [7:0] bits;
    logic [2:0] p3;
    logic [2:0] exp3;
    bits = 8'b1011_0000;
    p3   = 3'b101;
    exp3 = 3'b001;
    load_cfg(8'h00, 4'd0, 1'b1);
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_len0: got %b want 1", cfg_err);
    end
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 1'b0);
      total++;
      if (pattern_found !== 1'b0) begin
        bad++;
        $display("FAIL err_pf bit%0d: got %b want 0", 7 - i, pattern_found);
      end
    end
    load_cfg(8'h01, 4'd9, 1'b1);
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_len9: got %b want 1", cfg_err);
    end
    load_cfg(8'h05, 4'd3, 1'b1);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL err_len3: got %b want 0", cfg_err);
    end
    for (int i = 2; i >= 0; i--) begin
      step(1'b1, p3[i], 1'b0, 1'b0);
      total++;
      if (pattern_found !== exp3[i]) begin
        bad++;
        $display("FAIL len3_pf bit%0d: got %b want %b", 2 - i, pattern_found, exp3[i]);
      end
    end
  endtask

  task automatic test_back_to_back_sat;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_cfg(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (pattern_found !== 1'b1) begin
        bad++;
        $display("FAIL b2b_pf bit%0d: got %b want 1", i, pattern_found);
      end
    end
    total++;
    if (mc2 !== 3'd7 || sat2 !== 1'b1) begin
      bad++;
      $display("FAIL sat_small: got cnt=%0d sat=%b want cnt=7 sat=1", mc2, sat2);
    end
    total++;
    if (match_count !== 16'd9 || count_sat !== 1'b0) begin
      bad++;
      $display("FAIL sat_wide: got cnt=%0d sat=%b want cnt=9 sat=0", match_count, count_sat);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (mc2 !== 3'd1 || sat2 !== 1'b0 || match_count !== 16'd1) begin
      bad++;
      $display("FAIL clr_with_match: got small=%0d sat=%b wide=%0d want 1 0 1",
               mc2, sat2, match_count);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] bits;
    bits = 4'b1011;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
    for (int i = 3; i >= 1; i--) step(1'b1, bits[i], 1'b0, 1'b0);
    total++;
    if (match_count !== 16'd1) begin
      bad++;
      $display("FAIL pre_reset_count: got %0d want 1", match_count);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({pattern_found, match_count, count_sat, cfg_err} !== 19'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got pf=%b cnt=%0d sat=%b err=%b, want all 0",
               pattern_found, match_count, count_sat, cfg_err);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, bits[0], 1'b0, 1'b0);
    total++;
    if (pattern_found !== 1'b0 || match_count !== 16'd0) begin
      bad++;
      $display("FAIL after_reset: got pf=%b cnt=%0d want 0 0", pattern_found, match_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_default_overlap;
    test_non_overlap;
    test_gaps_and_reload;
    test_cfg_err;
    test_back_to_back_sat;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
